// File: rtl/mmio_bus_decoder.sv
// Address decoder and read-data mux between the CPU bus and N MMIO slaves.
// Optional fault statistics (err_count / err_addr) enabled by MMIO_ERR_CAPTURE_EN.
module mmio_bus_decoder #(
  parameter int                     N_SLAVES      = 4,
  parameter int                     READ_LATENCY  = 1,
  parameter logic [N_SLAVES*32-1:0] SLV_BASE      = {N_SLAVES{32'h0}},
  parameter logic [N_SLAVES*32-1:0] SLV_LIMIT     = {N_SLAVES{32'h0}},
  parameter logic [31:0]            DEFAULT_RDATA = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  input  logic                     mem_write,
  input  logic [3:0]               byte_mask,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      slv_sel,
  output logic [N_SLAVES-1:0]      slv_we,
  input  logic [N_SLAVES*32-1:0]   slv_rdata,
  output logic                     decode_err,
  output logic [15:0]              err_count,
  output logic [31:0]              err_addr
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  logic [N_SLAVES-1:0] hit_vec;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic                unmapped;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_win
      assign hit_vec[gi] = (mem_addr >= SLV_BASE[32*gi +: 32]) &&
                           (mem_addr <= SLV_LIMIT[32*gi +: 32]);
    end
  endgenerate

  // Descending scan so the lowest matching window ends up selected.
  always_comb begin
    dec_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (hit_vec[i]) dec_idx = IDX_W'(i);
    end
  end

  assign dec_hit  = |hit_vec;
  assign slv_sel  = hit_vec & ~(hit_vec - N_SLAVES'(1));
  assign slv_we   = (mem_valid && mem_write && !reset) ? slv_sel : '0;
  assign unmapped = mem_valid && !dec_hit;

  // Slaves take write data and byte enables straight from the CPU bus.
  logic unused_bcast;
  assign unused_bcast = ^{mem_wdata, byte_mask};

  logic [READ_LATENCY-1:0] pipe_hit_q, pipe_hit_d;
  logic [IDX_W-1:0]        pipe_idx_q [READ_LATENCY];
  logic [IDX_W-1:0]        pipe_idx_d [READ_LATENCY];

  always_comb begin
    pipe_hit_d    = pipe_hit_q;
    pipe_idx_d    = pipe_idx_q;
    pipe_hit_d[0] = dec_hit;
    pipe_idx_d[0] = dec_idx;
    for (int k = 1; k < READ_LATENCY; k++) begin
      pipe_hit_d[k] = pipe_hit_q[k-1];
      pipe_idx_d[k] = pipe_idx_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_hit_q <= '0;
      for (int k = 0; k < READ_LATENCY; k++) pipe_idx_q[k] <= '0;
    end else begin
      pipe_hit_q <= pipe_hit_d;
      for (int k = 0; k < READ_LATENCY; k++) pipe_idx_q[k] <= pipe_idx_d[k];
    end
  end

  always_comb begin
    mem_rdata = DEFAULT_RDATA;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (pipe_hit_q[READ_LATENCY-1] && (pipe_idx_q[READ_LATENCY-1] == IDX_W'(i)))
        mem_rdata = slv_rdata[32*i +: 32];
    end
  end

  logic decode_err_q, decode_err_d;

  always_comb decode_err_d = unmapped;

  always_ff @(posedge clk) begin
    if (reset) decode_err_q <= 1'b0;
    else       decode_err_q <= decode_err_d;
  end

  assign decode_err = decode_err_q;

`ifdef MMIO_ERR_CAPTURE_EN
  logic [15:0] err_count_q, err_count_d;
  logic [31:0] err_addr_q, err_addr_d;

  always_comb begin
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (unmapped) begin
      if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      err_addr_d = mem_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 16'h0000;
      err_addr_q  <= 32'h0000_0000;
    end else begin
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;
`else
  assign err_count = 16'h0000;
  assign err_addr  = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_mmio_bus_decoder.sv
// Directed bench for mmio_bus_decoder: four instances covering latency 1/2/3
// and overlapping windows, sharing one CPU-side stimulus.
module tb_mmio_bus_decoder;

`ifdef MMIO_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  byte_mask;

  logic [63:0] slv_rdata2 = {32'hCAFE_F00D, 32'hDEAD_BEEF};
  logic [95:0] slv_rdata3 = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  logic [31:0] r1, r2, r3, rov;
  logic [1:0]  sel1, we1, sel2, we2, sel3, we3;
  logic [2:0]  selov, weov;
  logic        derr1, derr2, derr3, derrov;
  logic [15:0] cnt1, cnt2, cnt3, cntov;
  logic [31:0] eaddr1, eaddr2, eaddr3, eaddrov;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mmio_bus_decoder #(
    .N_SLAVES(2), .READ_LATENCY(1),
    .SLV_BASE({32'hFFFF_FFF0, 32'h0000_0000}),
    .SLV_LIMIT({32'hFFFF_FFF3, 32'h0000_07FF}),
    .DEFAULT_RDATA(32'h0000_0000)
  ) u1 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .byte_mask(byte_mask),
    .mem_rdata(r1), .slv_sel(sel1), .slv_we(we1), .slv_rdata(slv_rdata2),
    .decode_err(derr1), .err_count(cnt1), .err_addr(eaddr1)
  );

  mmio_bus_decoder #(
    .N_SLAVES(2), .READ_LATENCY(2),
    .SLV_BASE({32'hFFFF_FFF0, 32'h0000_0000}),
    .SLV_LIMIT({32'hFFFF_FFF3, 32'h0000_07FF}),
    .DEFAULT_RDATA(32'hBAD0_BAD0)
  ) u2 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .byte_mask(byte_mask),
    .mem_rdata(r2), .slv_sel(sel2), .slv_we(we2), .slv_rdata(slv_rdata2),
    .decode_err(derr2), .err_count(cnt2), .err_addr(eaddr2)
  );

  mmio_bus_decoder #(
    .N_SLAVES(2), .READ_LATENCY(3),
    .SLV_BASE({32'hFFFF_FFF0, 32'h0000_0000}),
    .SLV_LIMIT({32'hFFFF_FFF3, 32'h0000_07FF}),
    .DEFAULT_RDATA(32'h0000_0000)
  ) u3 (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .byte_mask(byte_mask),
    .mem_rdata(r3), .slv_sel(sel3), .slv_we(we3), .slv_rdata(slv_rdata2),
    .decode_err(derr3), .err_count(cnt3), .err_addr(eaddr3)
  );

  mmio_bus_decoder #(
    .N_SLAVES(3), .READ_LATENCY(1),
    .SLV_BASE({32'h0000_0100, 32'h0000_1000, 32'h0000_0000}),
    .SLV_LIMIT({32'h0000_02FF, 32'h0000_1FFF, 32'h0000_01FF}),
    .DEFAULT_RDATA(32'h0000_0000)
  ) u_ov (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_write(mem_write), .byte_mask(byte_mask),
    .mem_rdata(rov), .slv_sel(selov), .slv_we(weov), .slv_rdata(slv_rdata3),
    .decode_err(derrov), .err_count(cntov), .err_addr(eaddrov)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seq [8];
    logic [31:0] exp3 [6];
    seq  = '{32'h0000_0004, 32'hFFFF_FFF0, 32'h1000_0000, 32'h0000_0008,
             32'hFFFF_FFF2, 32'h0000_2000, 32'h0000_2000, 32'h0000_2000};
    exp3 = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0000, 32'hDEAD_BEEF,
             32'hCAFE_F00D, 32'h0000_0000};

    // Reset with a mapped write on the bus: no strobe, select still decodes.
    reset = 1'b1; mem_valid = 1'b1; mem_write = 1'b1;
    mem_addr = 32'h0000_0004; mem_wdata = 32'h1234_5678; byte_mask = 4'hF;
    #2;
    chk("sel_in_reset", 32'(sel1), 32'h1);
    chk("we_in_reset", 32'(we1), 32'h0);
    tick();
    mem_addr = 32'h1000_0000;
    tick();
    reset = 1'b0; mem_valid = 1'b0; mem_write = 1'b0; mem_addr = 32'h0;
    chk("rst_rdata", r1, 32'h0);
    chk("rst_rdata_default", r2, 32'hBAD0_BAD0);
    chk("rst_decode_err", 32'(derr1), 32'h0);
    chk("rst_err_count", 32'(cnt1), 32'h0);
    chk("rst_err_addr", eaddr1, 32'h0);

    // Mapped read
    mem_valid = 1'b1; mem_addr = 32'h0000_0004;
    #1 chk("read_no_we", 32'(we1), 32'h0);
    tick();
    chk("read_rdata", r1, 32'hDEAD_BEEF);
    chk("read_no_err", 32'(derr1), 32'h0);

    // Mapped write to slave1
    mem_write = 1'b1; mem_addr = 32'hFFFF_FFF0; byte_mask = 4'b0001;
    #1 chk("write_we", 32'(we1), 32'h2);
    chk("write_sel", 32'(sel1), 32'h2);
    tick();
    chk("write_rdata", r1, 32'hCAFE_F00D);
    chk("write_no_err", 32'(derr1), 32'h0);

    // Window edges
    mem_addr = 32'h0000_07FF;
    #1 chk("edge_s0_top", 32'(we1), 32'h1);
    tick();
    mem_addr = 32'hFFFF_FFF3;
    #1 chk("edge_s1_top", 32'(we1), 32'h2);
    tick();

    // Unmapped read
    mem_write = 1'b0; mem_addr = 32'h1000_0000;
    #1 chk("unmap_sel", 32'(sel1), 32'h0);
    chk("unmap_we", 32'(we1), 32'h0);
    tick();
    chk("unmap_rdata", r1, 32'h0);
    chk("unmap_err", 32'(derr1), 32'h1);
    chk("unmap_count", 32'(cnt1), CAP ? 32'd1 : 32'd0);
    chk("unmap_addr", eaddr1, CAP ? 32'h1000_0000 : 32'h0);

    // Back-to-back unmapped writes just past each window
    mem_write = 1'b1; mem_addr = 32'h0000_0800;
    #1 chk("past_s0_we", 32'(we1), 32'h0);
    tick();
    chk("b2b_err1", 32'(derr1), 32'h1);
    mem_addr = 32'hFFFF_FFF4;
    #1 chk("past_s1_we", 32'(we1), 32'h0);
    tick();
    chk("b2b_err2", 32'(derr1), 32'h1);
    chk("b2b_count", 32'(cnt1), CAP ? 32'd3 : 32'd0);
    chk("b2b_addr", eaddr1, CAP ? 32'hFFFF_FFF4 : 32'h0);

    // Invalid cycle then a valid hit: error state untouched
    mem_valid = 1'b0; mem_write = 1'b0; mem_addr = 32'h2000_0000;
    tick();
    chk("pulse_end", 32'(derr1), 32'h0);
    mem_valid = 1'b1; mem_addr = 32'h0000_0004;
    tick();
    chk("hit_keeps_count", 32'(cnt1), CAP ? 32'd3 : 32'd0);
    chk("hit_keeps_addr", eaddr1, CAP ? 32'hFFFF_FFF4 : 32'h0);

    // Latency-3 pipeline, addresses change every cycle, mem_valid low
    mem_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem_addr = seq[k];
      tick();
      if (k >= 2) chk($sformatf("lat3_%0d", k), r3, exp3[k-2]);
    end

    // Overlapping windows: slave0 and slave2 both cover 0x100
    mem_addr = 32'h0000_0100;
    #1 chk("ovl_sel_100", 32'(selov), 32'h1);
    mem_addr = 32'h0000_0250;
    #1 chk("ovl_sel_250", 32'(selov), 32'h4);
    mem_addr = 32'h0000_1800;
    #1 chk("ovl_sel_1800", 32'(selov), 32'h2);
    mem_addr = 32'h0000_0250;
    tick();
    chk("ovl_rdata_s2", rov, 32'h3333_3333);
    mem_addr = 32'h0000_0100;
    tick();
    chk("ovl_rdata_s0", rov, 32'h1111_1111);

`ifdef MMIO_ERR_CAPTURE_EN
    force u1.err_count_q = 16'hFFFE;
    #1 release u1.err_count_q;
    mem_valid = 1'b1; mem_addr = 32'h3000_0000;
    tick();
    chk("sat_first", 32'(cnt1), 32'hFFFF);
    tick();
    tick();
    chk("sat_hold", 32'(cnt1), 32'hFFFF);
    chk("sat_addr", eaddr1, 32'h3000_0000);
`endif

    // Reset mid-stream on the latency-2 instance
    mem_valid = 1'b1; mem_write = 1'b0; mem_addr = 32'h0000_0004;
    tick();
    tick();
    chk("pre_rst_rdata", r2, 32'hDEAD_BEEF);
    mem_addr = 32'h1000_0000; reset = 1'b1;
    tick();
    reset = 1'b0; mem_valid = 1'b0;
    chk("mid_rst_rdata", r2, 32'hBAD0_BAD0);
    chk("mid_rst_err", 32'(derr2), 32'h0);
    chk("mid_rst_count2", 32'(cnt2), 32'h0);
    chk("mid_rst_count1", 32'(cnt1), 32'h0);
    tick();
    chk("post_rst_rdata1", r2, 32'hBAD0_BAD0);
    mem_addr = 32'h0000_0004;
    tick();
    chk("post_rst_rdata2", r2, 32'hBAD0_BAD0);
    tick();
    chk("post_rst_rdata3", r2, 32'hDEAD_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
